tog_evt_rx: RTL and testbench

TOG_EVT_RX -- requirements
Module: tog_evt_rx

---
 rtl/tog_evt_rx_if.sv | 25 ++
 rtl/tog_evt_rx.sv | 113 +++++++++++
 tb/tb_tog_evt_rx.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/tog_evt_rx_if.sv
// tog_evt_rx_if: toggle-event line, pending-event handshake and status for tog_evt_rx.
interface tog_evt_rx_if #(
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned PEND_W = 3
);
  logic              t;
  logic              evt_valid;
  logic              evt_ready;
  logic [PEND_W-1:0] pend_cnt;
  logic [CNT_W-1:0]  evt_total;
  logic              ovf;
  logic              clr_ovf;

  // Consumer/transmitter side
  modport master (
    output t, evt_ready, clr_ovf,
    input  evt_valid, pend_cnt, evt_total, ovf
  );

  // Receiver side
  modport slave (
    input  t, evt_ready, clr_ovf,
    output evt_valid, pend_cnt, evt_total, ovf
  );
endinterface

// File: rtl/tog_evt_rx.sv
// tog_evt_rx: turns level changes on a TFF toggle line into counted, handshaked events.
// Define TOG_EVT_RX_SYNC_EN for a two-stage input synchronizer; otherwise one stage.
module tog_evt_rx #(
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned PEND_W = 3
) (
  input  logic        clk,
  input  logic        reset,
  tog_evt_rx_if.slave bus
);
  localparam logic [PEND_W-1:0] PMAX = {PEND_W{1'b1}};

  typedef enum logic {ST_PRIME = 1'b0, ST_RUN = 1'b1} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_prime;
  logic              r_s1;
  logic              w_sync;
  logic              r_p;
  logic              r_edge;
  logic [PEND_W-1:0] r_pend;
  logic [PEND_W-1:0] w_pend_nxt;
  logic              r_evt_valid;
  logic [CNT_W-1:0]  r_total;
  logic              r_ovf;
  logic              w_accept;
  logic              w_full;
  logic              w_drop;

  // Input synchronizer; on reset every stage loads t so the held level is not an event
`ifdef TOG_EVT_RX_SYNC_EN
  logic r_s2;
  always_ff @(posedge clk) begin
    r_s1 <= bus.t;
    if (reset) r_s2 <= bus.t;
    else       r_s2 <= r_s1;
  end
  assign w_sync = r_s2;
`else
  always_ff @(posedge clk) begin
    r_s1 <= bus.t;
  end
  assign w_sync = r_s1;
`endif

  // Detector state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_PRIME;
    else       r_state <= w_state_nxt;
  end

  // Detector next state: one priming cycle, then run until reset
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_PRIME: w_state_nxt = ST_RUN;
      ST_RUN:   w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_PRIME;
    endcase
  end

  // Detector outputs
  always_comb begin
    w_prime = 1'b0;
    if (r_state == ST_PRIME) w_prime = 1'b1;
  end

  // Registered one-cycle edge pulse per sampled level change
  always_ff @(posedge clk) begin
    if (reset) begin
      r_p    <= bus.t;
      r_edge <= 1'b0;
    end else begin
      r_p    <= w_sync;
      r_edge <= w_prime ? 1'b0 : (w_sync ^ r_p);
    end
  end

  // Pending count: a full queue drops a lone edge but absorbs edge+accept
  always_comb begin
    w_accept   = r_evt_valid & bus.evt_ready;
    w_full     = (r_pend == PMAX);
    w_drop     = r_edge & ~w_accept & w_full;
    w_pend_nxt = r_pend;
    unique case ({r_edge, w_accept})
      2'b10:   w_pend_nxt = w_full ? r_pend : r_pend + PEND_W'(1);
      2'b01:   w_pend_nxt = r_pend - PEND_W'(1);
      default: w_pend_nxt = r_pend;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend      <= '0;
      r_evt_valid <= 1'b0;
      r_total     <= '0;
      r_ovf       <= 1'b0;
    end else begin
      r_pend      <= w_pend_nxt;
      r_evt_valid <= (w_pend_nxt != '0);
      r_total     <= r_total + CNT_W'(r_edge);
      // A new loss outranks a simultaneous clear
      if (w_drop)           r_ovf <= 1'b1;
      else if (bus.clr_ovf) r_ovf <= 1'b0;
    end
  end

  assign bus.evt_valid = r_evt_valid;
  assign bus.pend_cnt  = r_pend;
  assign bus.evt_total = r_total;
  assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_tog_evt_rx.sv
// tb_tog_evt_rx: directed self-checking bench for tog_evt_rx (CNT_W=8, PEND_W=3).
module tb_tog_evt_rx;
`ifdef TOG_EVT_RX_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic clk;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  tog_evt_rx_if #(.CNT_W(8), .PEND_W(3)) bus ();

  tog_evt_rx #(.CNT_W(8), .PEND_W(3)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges and park on the following falling edge
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(2);
  endtask

  task automatic test_reset();
    bus.t = 1'b1; bus.evt_ready = 1'b0; bus.clr_ovf = 1'b0; reset = 1'b1;
    step(3);
    n_cmp++; if (bus.pend_cnt !== 3'd0) begin n_err++; $display("FAIL rst_pend: got %0d want 0", bus.pend_cnt); end
    n_cmp++; if (bus.evt_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", bus.evt_valid); end
    n_cmp++; if (bus.evt_total !== 8'd0) begin n_err++; $display("FAIL rst_total: got %0d want 0", bus.evt_total); end
    n_cmp++; if (bus.ovf !== 1'b0) begin n_err++; $display("FAIL rst_ovf: got %b want 0", bus.ovf); end
    reset = 1'b0;
    step(10);
    n_cmp++; if (bus.evt_total !== 8'd0) begin n_err++; $display("FAIL hold_total: got %0d want 0", bus.evt_total); end
    n_cmp++; if (bus.pend_cnt !== 3'd0) begin n_err++; $display("FAIL hold_pend: got %0d want 0", bus.pend_cnt); end
    n_cmp++; if (bus.evt_valid !== 1'b0) begin n_err++; $display("FAIL hold_valid: got %b want 0", bus.evt_valid); end
  endtask

  task automatic test_fill();
    bus.evt_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      bus.t = ~bus.t;
      step(LAT);
      n_cmp++; if (bus.pend_cnt !== 3'(i - 1)) begin n_err++; $display("FAIL fill_early%0d: got %0d want %0d", i, bus.pend_cnt, i - 1); end
      step(1);
      n_cmp++; if (bus.pend_cnt !== 3'(i)) begin n_err++; $display("FAIL fill_pend%0d: got %0d want %0d", i, bus.pend_cnt, i); end
      n_cmp++; if (bus.evt_valid !== 1'b1) begin n_err++; $display("FAIL fill_valid%0d: got %b want 1", i, bus.evt_valid); end
      step(3 - LAT);
    end
    n_cmp++; if (bus.evt_total !== 8'd3) begin n_err++; $display("FAIL fill_total: got %0d want 3", bus.evt_total); end
  endtask

  task automatic test_drain();
    bus.evt_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step(1);
      n_cmp++; if (bus.pend_cnt !== 3'(3 - i)) begin n_err++; $display("FAIL drain_pend%0d: got %0d want %0d", i, bus.pend_cnt, 3 - i); end
      n_cmp++; if (bus.evt_valid !== (i != 3)) begin n_err++; $display("FAIL drain_valid%0d: got %b want %b", i, bus.evt_valid, i != 3); end
    end
    bus.evt_ready = 1'b0;
    step(2);
    n_cmp++; if (bus.evt_total !== 8'd3) begin n_err++; $display("FAIL drain_total: got %0d want 3", bus.evt_total); end
  endtask

  task automatic test_overflow();
    do_reset();
    bus.evt_ready = 1'b0;
    repeat (8) begin
      bus.t = ~bus.t;
      step(2);
    end
    step(LAT + 1);
    n_cmp++; if (bus.pend_cnt !== 3'd7) begin n_err++; $display("FAIL ovf_pend: got %0d want 7", bus.pend_cnt); end
    n_cmp++; if (bus.ovf !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b want 1", bus.ovf); end
    n_cmp++; if (bus.evt_total !== 8'd8) begin n_err++; $display("FAIL ovf_total: got %0d want 8", bus.evt_total); end
    bus.clr_ovf = 1'b1;
    step(1);
    bus.clr_ovf = 1'b0;
    n_cmp++; if (bus.ovf !== 1'b0) begin n_err++; $display("FAIL ovf_clr: got %b want 0", bus.ovf); end
    n_cmp++; if (bus.pend_cnt !== 3'd7) begin n_err++; $display("FAIL ovf_clr_pend: got %0d want 7", bus.pend_cnt); end
  endtask

  task automatic test_full_accept();
    bus.t = ~bus.t;
    step(LAT);
    bus.evt_ready = 1'b1;
    step(1);
    bus.evt_ready = 1'b0;
    n_cmp++; if (bus.pend_cnt !== 3'd7) begin n_err++; $display("FAIL fa_pend: got %0d want 7", bus.pend_cnt); end
    n_cmp++; if (bus.ovf !== 1'b0) begin n_err++; $display("FAIL fa_ovf: got %b want 0", bus.ovf); end
    n_cmp++; if (bus.evt_total !== 8'd9) begin n_err++; $display("FAIL fa_total: got %0d want 9", bus.evt_total); end
    bus.t = ~bus.t;
    step(LAT);
    bus.clr_ovf = 1'b1;
    step(1);
    bus.clr_ovf = 1'b0;
    n_cmp++; if (bus.ovf !== 1'b1) begin n_err++; $display("FAIL set_wins_ovf: got %b want 1", bus.ovf); end
    n_cmp++; if (bus.pend_cnt !== 3'd7) begin n_err++; $display("FAIL set_wins_pend: got %0d want 7", bus.pend_cnt); end
    n_cmp++; if (bus.evt_total !== 8'd10) begin n_err++; $display("FAIL set_wins_total: got %0d want 10", bus.evt_total); end
    bus.clr_ovf = 1'b1;
    step(1);
    bus.clr_ovf = 1'b0;
    n_cmp++; if (bus.ovf !== 1'b0) begin n_err++; $display("FAIL late_clr: got %b want 0", bus.ovf); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.evt_ready = 1'b1;
    repeat (257) begin
      bus.t = ~bus.t;
      step(1);
    end
    step(LAT + 2);
    bus.evt_ready = 1'b0;
    n_cmp++; if (bus.evt_total !== 8'd1) begin n_err++; $display("FAIL wrap_total: got %0d want 1", bus.evt_total); end
    n_cmp++; if (bus.pend_cnt !== 3'd0) begin n_err++; $display("FAIL wrap_pend: got %0d want 0", bus.pend_cnt); end
    n_cmp++; if (bus.evt_valid !== 1'b0) begin n_err++; $display("FAIL wrap_valid: got %b want 0", bus.evt_valid); end
    n_cmp++; if (bus.ovf !== 1'b0) begin n_err++; $display("FAIL wrap_ovf: got %b want 0", bus.ovf); end
  endtask

  task automatic test_reset_mid();
    bus.evt_ready = 1'b0;
    repeat (10) begin
      bus.t = ~bus.t;
      step(1);
    end
    step(LAT);
    n_cmp++; if (bus.pend_cnt !== 3'd7) begin n_err++; $display("FAIL mid_pre_pend: got %0d want 7", bus.pend_cnt); end
    n_cmp++; if (bus.ovf !== 1'b1) begin n_err++; $display("FAIL mid_pre_ovf: got %b want 1", bus.ovf); end
    n_cmp++; if (bus.evt_total !== 8'd11) begin n_err++; $display("FAIL mid_pre_total: got %0d want 11", bus.evt_total); end
    bus.t = ~bus.t; bus.evt_ready = 1'b1; bus.clr_ovf = 1'b1; reset = 1'b1;
    step(1);
    n_cmp++; if (bus.pend_cnt !== 3'd0) begin n_err++; $display("FAIL mid_pend: got %0d want 0", bus.pend_cnt); end
    n_cmp++; if (bus.evt_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid: got %b want 0", bus.evt_valid); end
    n_cmp++; if (bus.evt_total !== 8'd0) begin n_err++; $display("FAIL mid_total: got %0d want 0", bus.evt_total); end
    n_cmp++; if (bus.ovf !== 1'b0) begin n_err++; $display("FAIL mid_ovf: got %b want 0", bus.ovf); end
    bus.evt_ready = 1'b0; bus.clr_ovf = 1'b0;
    step(1);
    reset = 1'b0;
    step(LAT + 4);
    n_cmp++; if (bus.evt_total !== 8'd0) begin n_err++; $display("FAIL post_rst_total: got %0d want 0", bus.evt_total); end
    n_cmp++; if (bus.pend_cnt !== 3'd0) begin n_err++; $display("FAIL post_rst_pend: got %0d want 0", bus.pend_cnt); end
  endtask

  initial begin
    reset = 1'b1;
    bus.t = 1'b1;
    bus.evt_ready = 1'b0;
    bus.clr_ovf = 1'b0;
    @(negedge clk);
    test_reset();
    test_fill();
    test_drain();
    test_overflow();
    test_full_accept();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
